// File: rtl/multicycle_core_if.sv
// multicycle_core_if: instruction and data memory req/ack buses between core (master) and memories (slave)
interface multicycle_core_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/MEM/WB multi-cycle core on req/ack memories; define CORE_PERF_CNT_EN for perf counters
module multicycle_core #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    multicycle_core_if.master bus,
    output logic              halted,
    output logic              retire,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic              dbg_wb_we,
    output logic [4:0]        dbg_wb_addr,
    output logic [DATA_W-1:0] dbg_wb_data
`ifdef CORE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
`endif
);
    localparam int RI = $clog2(NUM_REGS);
    localparam logic [1:0] T_ALU = 2'b00, T_MEM = 2'b01, T_BR = 2'b10, T_HALT = 2'b11;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t            state, state_nx;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc, pc_inc;
    logic              flag_n, flag_z;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] a_q, b_q, d_q, res_q, ld_q;
    logic [3:0]        cond;
    logic [1:0]        ty, op, alu_op;
    logic              imm_en, set_flags, l_bit, cond_ok, wb_we, wb_link;
    logic [4:0]        rd, rh, ro, wb_addr;
    logic [DATA_W-1:0] imm, rh_val, ro_val, rd_val, alu, wb_data;

    assign {cond, ty, imm_en, op, set_flags, l_bit, rd, rh, ro} = ir[31:6];
    assign imm     = {{(DATA_W-11){ir[10]}}, ir[10:0]};
    assign pc_inc  = pc + ADDR_W'(1);
    assign rh_val  = (32'(rh) < NUM_REGS) ? regs[rh[RI-1:0]] : '0;
    assign ro_val  = (32'(ro) < NUM_REGS) ? regs[ro[RI-1:0]] : '0;
    assign rd_val  = (32'(rd) < NUM_REGS) ? regs[rd[RI-1:0]] : '0;
    assign cond_ok = (cond == 4'd0) | ((cond == 4'd1) & flag_z) | ((cond == 4'd2) & ~flag_z)
                   | ((cond == 4'd3) & flag_n) | ((cond == 4'd4) & ~flag_n);
    assign alu_op  = (ty == T_ALU) ? op : 2'b00;
    assign alu     = (alu_op == 2'd0) ? a_q + b_q :
                     (alu_op == 2'd1) ? a_q - b_q :
                     (alu_op == 2'd2) ? a_q & b_q : a_q | b_q;

    // Next-state sequencing, bus requests, writeback selection and debug outputs
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = bus.imem_ack ? DECODE : FETCH;
            DECODE:  state_nx = !cond_ok ? FETCH : (ty == T_HALT) ? HALT : EXEC;
            EXEC:    state_nx = (ty == T_MEM) ? MEM : WB;
            MEM:     state_nx = bus.dmem_ack ? WB : MEM;
            WB:      state_nx = FETCH;
            default: state_nx = HALT;
        endcase
        bus.imem_req   = (state == FETCH) & ~reset;
        bus.imem_addr  = bus.imem_req ? pc : '0;
        bus.dmem_req   = (state == MEM) & ~reset;
        bus.dmem_we    = bus.dmem_req & ~l_bit;
        bus.dmem_addr  = bus.dmem_req ? ADDR_W'(res_q) : '0;
        bus.dmem_wdata = bus.dmem_req ? d_q : '0;
        wb_link        = (ty == T_BR) & l_bit;
        wb_addr        = wb_link ? 5'(NUM_REGS - 1) : rd;
        wb_data        = (ty == T_ALU) ? res_q : (ty == T_MEM) ? ld_q : DATA_W'(pc_inc);
        wb_we          = (state == WB) & ((ty == T_ALU) | ((ty == T_MEM) & l_bit) | wb_link)
                       & (32'(wb_addr) < NUM_REGS);
        halted         = state == HALT;
        retire         = (state == WB) | ((state == DECODE) & ~cond_ok);
        dbg_pc         = pc;
        dbg_wb_we      = wb_we;
        dbg_wb_addr    = wb_we ? wb_addr : '0;
        dbg_wb_data    = wb_we ? wb_data : '0;
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FETCH;
        else state <= state_nx;
    end

    // Datapath: instruction capture, operand latch, execute result, flags, load data and PC
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            res_q  <= '0;
            ld_q   <= '0;
        end else begin
            if (state == FETCH && bus.imem_ack) ir <= bus.imem_rdata;
            if (state == DECODE) begin
                a_q <= rh_val;
                b_q <= imm_en ? imm : ro_val;
                d_q <= rd_val;
                if (!cond_ok) pc <= pc_inc;
            end
            if (state == EXEC) begin
                res_q <= alu;
                if (ty == T_ALU && set_flags) begin
                    flag_n <= alu[DATA_W-1];
                    flag_z <= alu == '0;
                end
            end
            if (state == MEM && bus.dmem_ack && l_bit) ld_q <= bus.dmem_rdata;
            if (state == WB) pc <= (ty == T_BR) ? ADDR_W'(res_q) : pc_inc;
        end
    end

    // Register file: single write port driven by writeback
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wb_addr[RI-1:0]] <= wb_data;
        end
    end

`ifdef CORE_PERF_CNT_EN
    // Performance counters: cycles stop advancing once halted, retires count every retire pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
        end else begin
            if (state != HALT) perf_cycles <= perf_cycles + 32'd1;
            if (retire) perf_retired <= perf_retired + 32'd1;
        end
    end
`endif
endmodule
